// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS I core and a word-wide data memory.
// Sizes and aligns byte/half/word accesses, with read-modify-write for SB/SH.
module load_store_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic [5:0]  opcode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        addr_err_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic [31:0] mem_rd_data_i
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WR1   = 3'd3;
    localparam logic [2:0] S_WR2   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic in_half, in_word, in_valid, in_misal;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [4:0]  sh_b, sh_h;
    logic [31:0] rd_b, rd_h;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val, merged;

    assign in_half = (opcode_i == OP_LH) || (opcode_i == OP_LHU) ||
                     (opcode_i == OP_SH);
    assign in_word = (opcode_i == OP_LW) || (opcode_i == OP_SW);
    assign in_valid = in_half || in_word || (opcode_i == OP_LB) ||
                      (opcode_i == OP_LBU) || (opcode_i == OP_SB);
    assign in_misal = (in_half && addr_i[0]) ||
                      (in_word && (addr_i[1:0] != 2'b00));

    // Bit position of the addressed lane within the memory word
    assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
    assign half_lane = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
    assign sh_b = {byte_lane, 3'b000};
    assign sh_h = {half_lane, 4'b0000};

    assign rd_b = mem_rd_data_i >> sh_b;
    assign rd_h = mem_rd_data_i >> sh_h;
    assign ld_byte = rd_b[7:0];
    assign ld_half = rd_h[15:0];

    always_comb begin
        ld_val = '0;
        merged = mem_rd_data_i;
        unique case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'h0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'h0, ld_half};
            OP_LW:   ld_val = mem_rd_data_i;
            OP_SB:   merged = (mem_rd_data_i & ~(32'h0000_00FF << sh_b)) |
                              ({24'h0, wdata_q[7:0]} << sh_b);
            OP_SH:   merged = (mem_rd_data_i & ~(32'h0000_FFFF << sh_h)) |
                              ({16'h0, wdata_q[15:0]} << sh_h);
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    op_d    = opcode_i;
                    wdata_d = wdata_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (!in_valid) begin
                        state_d = S_DONE;
                    end else if (in_misal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (opcode_i == OP_SW) begin
                        state_d = S_WR1;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = S_RDATA;
            S_RDATA: begin
                if ((op_q == OP_SB) || (op_q == OP_SH)) begin
                    wdata_d = merged;
                    state_d = S_WR1;
                end else begin
                    rdata_d = ld_val;
                    state_d = S_DONE;
                end
            end
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Write enable decoded from state so a reset in WR1 drops it at once
    assign mem_wr_en_o   = (state_q == S_WR1);
    assign mem_rd_en_o   = ~mem_wr_en_o;
    assign mem_addr_o    = {2'b00, addr_q[31:2]};
    assign mem_wr_data_o = wdata_q;

    assign done_o     = (state_q == S_DONE);
    assign rdata_o    = rdata_q;
    assign addr_err_o = err_q;
    assign stall_o    = (state_q != S_DONE) &&
                        (req_i || (state_q != S_IDLE));

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model plus a scoreboard of
// expected completions checked when done_o pulses.
module tb_load_store_unit;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic [5:0]  opcode_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, addr_err_o;
    logic [31:0] rdata_o;
    logic        mem_rd_en_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_wr_data_o;
    logic [31:0] mem_rd_data_i;

    always #5 clk = ~clk;

    load_store_unit #(.BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i),
        .opcode_i(opcode_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .addr_err_o(addr_err_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rd_data_i(mem_rd_data_i)
    );

    // Memory: registers its write enable, commits at the end of W2
    logic [31:0] mem [64];
    logic        wr_q = 1'b0;
    always @(posedge clk) begin
        wr_q <= mem_wr_en_o;
        if (wr_q) mem[mem_addr_o[5:0]] <= mem_wr_data_o;
        mem_rd_data_i <= mem[mem_addr_o[5:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    bit          from_done = 1'b0;
    bit          chk_stall = 1'b0;
    bit          mon_en = 1'b0;
    bit          prev_wr = 1'b0;
    logic [31:0] pa, pd, last_addr, last_data;
    int          wr_cnt = 0;
    int          overlap = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_wr_en_o && mem_rd_en_o) overlap++;
            if (prev_wr) begin
                chk("w2_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
                chk("w2_rd_en", {31'b0, mem_rd_en_o}, 32'd1);
                chk("w2_addr", mem_addr_o, pa);
                chk("w2_data", mem_wr_data_o, pd);
            end
            prev_wr = mem_wr_en_o;
            if (mem_wr_en_o) begin
                wr_cnt++;
                pa = mem_addr_o;
                pd = mem_wr_data_o;
                last_addr = mem_addr_o;
                last_data = mem_wr_data_o;
            end
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic run(input string tag, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input bit chk_rd,
                       input bit err, input int lat, input bit hold);
        exp_t e;
        bit   got;
        sb.push_back('{tag, rd, chk_rd, err, lat + (from_done ? 1 : 0)});
        req_i    = 1'b1;
        opcode_i = op;
        addr_i   = a;
        wdata_i  = wd;
        got      = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (chk_stall)
                chk({tag, ".stall"}, {31'b0, stall_o}, {31'b0, !done_o});
            if (done_o) begin
                e = sb.pop_front();
                chk({e.tag, ".err"}, {31'b0, addr_err_o}, {31'b0, e.err});
                if (e.chk_rd) chk({e.tag, ".rdata"}, rdata_o, e.rd);
                chk({e.tag, ".lat"}, i, e.lat);
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk({tag, ".timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        from_done = hold;
        if (!hold) begin
            req_i = 1'b0;
            @(negedge clk);
        end
    endtask

    int wc;

    initial begin
        rst_n    = 1'b0;
        req_i    = 1'b0;
        opcode_i = '0;
        addr_i   = '0;
        wdata_i  = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        @(negedge clk);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_err", {31'b0, addr_err_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en_o}, 32'd1);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wr_data_o, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        run("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 0, 0, 0, 3, 0);
        chk("sw10.waddr", last_addr, 32'h4);
        chk("sw10.wdata", last_data, 32'hDEADBEEF);
        chk("sw10.mem", mem[4], 32'hDEADBEEF);

        run("sw_init", OP_SW, 32'h10, 32'h11223344, 0, 0, 0, 3, 0);
        run("sb13", OP_SB, 32'h13, 32'h000000A5, 0, 0, 0, 5, 0);
        chk("sb13.wdata", last_data, 32'hA5223344);
        chk("sb13.mem", mem[4], 32'hA5223344);
        run("sh12", OP_SH, 32'h12, 32'h0000BEEF, 0, 0, 0, 5, 0);
        chk("sh12.mem", mem[4], 32'hBEEF3344);

        run("sw_ld", OP_SW, 32'h10, 32'h80FF7F01, 0, 0, 0, 3, 0);
        run("lb13", OP_LB, 32'h13, 0, 32'hFFFFFF80, 1, 0, 3, 0);
        run("lbu13", OP_LBU, 32'h13, 0, 32'h00000080, 1, 0, 3, 0);
        run("lh12", OP_LH, 32'h12, 0, 32'hFFFF80FF, 1, 0, 3, 0);
        run("lhu10", OP_LHU, 32'h10, 0, 32'h00007F01, 1, 0, 3, 0);
        run("lb10", OP_LB, 32'h10, 0, 32'h00000001, 1, 0, 3, 0);
        run("lw10", OP_LW, 32'h10, 0, 32'h80FF7F01, 1, 0, 3, 0);

        wc = wr_cnt;
        run("lw_mis", OP_LW, 32'h6, 0, 0, 0, 1, 1, 0);
        run("sh_mis", OP_SH, 32'h5, 32'h1234, 0, 0, 1, 1, 0);
        run("unsup", 6'h00, 32'h10, 0, 32'h0, 1, 0, 1, 0);
        chk("mis_nowr", wr_cnt, wc);

        mon_en  = 1'b0;
        mem[12] = 32'hCAFE0000;
        req_i    = 1'b1;
        opcode_i = OP_SW;
        addr_i   = 32'h30;
        wdata_i  = 32'h12345678;
        @(posedge clk);
        #1;
        chk("w1_wr_en", {31'b0, mem_wr_en_o}, 32'd1);
        chk("w1_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_w1_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
        chk("rst_w1_rd_en", {31'b0, mem_rd_en_o}, 32'd1);
        chk("rst_w1_stall_hi", {31'b0, stall_o}, 32'd1);
        req_i = 1'b0;
        #1;
        chk("rst_w1_stall_lo", {31'b0, stall_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_w1_mem", mem[12], 32'hCAFE0000);
        from_done = 1'b0;
        mon_en    = 1'b1;

        chk_stall = 1'b1;
        run("b2b_sw", OP_SW, 32'h20, 32'h5A5AA5A5, 0, 0, 0, 3, 1);
        run("b2b_lw", OP_LW, 32'h20, 0, 32'h5A5AA5A5, 1, 0, 3, 0);
        chk_stall = 1'b0;

        chk("rd_wr_overlap", overlap, 0);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
